traffic_light_monitor: RTL and testbench
========================================

// Module: traffic_light_monitor
// PURPOSE
//  Passive checker/decoder on the light outputs of the traffic light controller.
//  Samples o_red/o_yellow/o_green plus the car request. Decodes them back into
//  a phase, measures the dwell time of each phase and counts completed cycles.
//  Raises sticky errors on illegal light codes, illegal sequences, over-long
//  yellow/green and starved car requests. Sits beside the controller in lab
//  top-levels and in benches.
// PARAMETERS
//  CNT_W        8   width of the dwell and cycle counters
//  MAX_DWELL    1   max legal consecutive samples in YELLOW or GREEN
//  CAR_TIMEOUT  8   max samples in RED with car asserted before starvation
// PORTS
//  i_clk        in   1      single clock, rising edge
//  i_reset      in   1      synchronous, active-high reset
//  i_red        in   1      observed red light
//  i_yellow     in   1      observed yellow light
//  i_green      in   1      observed green light
//  i_car        in   1      observed car request (same signal the controller sees)
//  i_clear_err  in   1      one-cycle pulse; clears o_err_code
//  o_phase      out  2      decoded phase: 0 SYNC, 1 RED, 2 YELLOW, 3 GREEN
//  o_dwell      out  CNT_W  samples spent in current phase, saturating
//  o_cycle_cnt  out  CNT_W  completed RED->YELLOW->GREEN->RED cycles, wraps
//  o_err_code   out  4      sticky: [0] bad code, [1] bad sequence, [2] dwell, [3] starve
//  o_err        out  1      OR of o_err_code
// BEHAVIOUR
//  - Reset (i_reset=1 at edge): all outputs 0, FSM in SYNC, input regs cleared.
//    Reset mid-operation has the same effect; no error is flagged for the cut.
//  - Stage 1 registers {red,yellow,green,car}. Stage 2 FSM/outputs update from
//    stage 1. A light value present before edge t shows on o_phase after t+1.
//  - Legal codes are one-hot only. 000 or multi-hot sets err[0]. The FSM holds
//    its phase and o_dwell keeps counting.
//  - FSM SYNC: first legal code is adopted with no sequence check. dwell=1.
//  - Legal transitions: RED->RED, RED->YELLOW only if the previous sample had
//    car=1, YELLOW->GREEN, GREEN->RED. Same phase held: dwell+1, saturating.
//  - Any other change sets err[1]. The monitor resyncs to the new phase, dwell=1.
//  - GREEN->RED legal: o_cycle_cnt+1, wraps at 2^CNT_W.
//  - err[2]: set on the sample where a YELLOW/GREEN dwell would reach MAX_DWELL+1.
//  - err[3]: set when in RED with registered car=1 for CAR_TIMEOUT+1 consecutive
//    samples. The run counter clears when car=0 or on leaving RED.
//  - Error bits are sticky until i_clear_err. If a new error and i_clear_err
//    land on the same edge, the new error bit ends set and the others clear.
//  - o_err is registered with o_err_code, so both are valid on the same cycle.
// CONFIGURATION
//  TRAFFIC_MON_STARVE_CHK_EN: defined -> starvation counter and err[3] present.
//  Undefined -> no counter logic, o_err_code[3] tied 0, CAR_TIMEOUT unused.
// TESTING
//  1 reset; lights=R, car=0 for 10 clk -> phase=1, dwell=10, err_code=0
//  2 from 1: car=1 one clk, lights R,Y,G,R one clk each -> cycle_cnt=1, err=0
//  3 lights R then G directly -> err_code=4'b0010, phase=3, dwell=1
//  4 lights=3'b110 one clk -> err_code[0]=1, phase unchanged; i_clear_err -> 0
//  5 MAX_DWELL=1, yellow held 3 clk -> err_code[2] set on 2nd yellow sample
//  6 macro on, CAR_TIMEOUT=8, car=1 while red held 9 samples -> err_code[3]=1;
//    macro off -> err_code stays 0
//  7 reset pulse mid-GREEN -> all outputs 0 next cycle, phase=SYNC, no error

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Passive monitor for traffic light controller outputs: decodes the phase, tracks dwell and cycles, and flags sticky errors.
// Optional starvation checker enabled by defining TRAFFIC_MON_STARVE_CHK_EN.
module traffic_light_monitor #(
    parameter int CNT_W       = 8,
    parameter int MAX_DWELL   = 1,
    parameter int CAR_TIMEOUT = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_red,
    input  logic             i_yellow,
    input  logic             i_green,
    input  logic             i_car,
    input  logic             i_clear_err,
    output logic [1:0]       o_phase,
    output logic [CNT_W-1:0] o_dwell,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [3:0]       o_err_code,
    output logic             o_err
);

    typedef enum logic [1:0] {
        PH_SYNC   = 2'd0,
        PH_RED    = 2'd1,
        PH_YELLOW = 2'd2,
        PH_GREEN  = 2'd3
    } phase_t;

    localparam logic [CNT_W-1:0] DWELL_MAX_VAL = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DWELL_LIMIT   = CNT_W'(MAX_DWELL);
    localparam logic [CNT_W-1:0] DWELL_ONE     = CNT_W'(1);

    // Stage 1: input sample registers
    logic [2:0] lights_reg;
    logic       car_reg;
    logic       valid_reg;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lights_reg <= 3'b000;
            car_reg    <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            lights_reg <= {i_red, i_yellow, i_green};
            car_reg    <= i_car;
            valid_reg  <= 1'b1;
        end
    end

    logic   code_ok;
    phase_t code_phase;

    always_comb begin
        code_ok    = 1'b1;
        code_phase = PH_SYNC;
        case (lights_reg)
            3'b100:  code_phase = PH_RED;
            3'b010:  code_phase = PH_YELLOW;
            3'b001:  code_phase = PH_GREEN;
            default: code_ok    = 1'b0;
        endcase
    end

    // Stage 2: phase tracking state
    phase_t           phase_reg, phase_next;
    logic [CNT_W-1:0] dwell_reg, dwell_next;
    logic [CNT_W-1:0] cycle_reg, cycle_next;
    logic             car_last_reg, car_last_next;
    logic [3:0]       err_code_reg, err_code_next;
    logic             err_reg;
    logic [2:0]       err_found;
    logic             starve_hit;
    logic [CNT_W-1:0] dwell_inc;
    logic             step_legal;

    assign dwell_inc = (dwell_reg == DWELL_MAX_VAL) ? dwell_reg : dwell_reg + DWELL_ONE;

    always_comb begin
        step_legal = 1'b0;
        case (phase_reg)
            PH_RED:    step_legal = (code_phase == PH_YELLOW) && car_last_reg;
            PH_YELLOW: step_legal = (code_phase == PH_GREEN);
            PH_GREEN:  step_legal = (code_phase == PH_RED);
            default:   step_legal = 1'b0;
        endcase
    end

    always_comb begin
        phase_next    = phase_reg;
        dwell_next    = dwell_reg;
        cycle_next    = cycle_reg;
        car_last_next = car_last_reg;
        err_found     = 3'b000;
        if (valid_reg) begin
            car_last_next = car_reg;
            if (!code_ok) begin
                err_found[0] = 1'b1;
                dwell_next   = dwell_inc;
            end else if (phase_reg == PH_SYNC) begin
                phase_next = code_phase;
                dwell_next = DWELL_ONE;
            end else if (code_phase == phase_reg) begin
                dwell_next = dwell_inc;
                if ((phase_reg == PH_YELLOW || phase_reg == PH_GREEN) && dwell_reg == DWELL_LIMIT)
                    err_found[2] = 1'b1;
            end else begin
                // Illegal changes still resync so later checks track the real lights
                phase_next = code_phase;
                dwell_next = DWELL_ONE;
                if (!step_legal)
                    err_found[1] = 1'b1;
                else if (phase_reg == PH_GREEN)
                    cycle_next = cycle_reg + DWELL_ONE;
            end
        end
    end

`ifdef TRAFFIC_MON_STARVE_CHK_EN
    localparam int STARVE_W = $clog2(CAR_TIMEOUT + 2);
    localparam logic [STARVE_W-1:0] STARVE_AT  = STARVE_W'(CAR_TIMEOUT);
    localparam logic [STARVE_W-1:0] STARVE_SAT = STARVE_W'(CAR_TIMEOUT + 1);

    logic [STARVE_W-1:0] starve_cnt_reg, starve_cnt_next;

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        starve_hit      = 1'b0;
        if (valid_reg) begin
            if (phase_next == PH_RED && car_reg) begin
                if (starve_cnt_reg != STARVE_SAT)
                    starve_cnt_next = starve_cnt_reg + STARVE_W'(1);
                if (starve_cnt_reg == STARVE_AT)
                    starve_hit = 1'b1;
            end else begin
                starve_cnt_next = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            starve_cnt_reg <= '0;
        else
            starve_cnt_reg <= starve_cnt_next;
    end
`else
    logic [31:0] unused_car_timeout;
    assign unused_car_timeout = CAR_TIMEOUT;
    assign starve_hit         = 1'b0;
`endif

    // A fresh error survives a simultaneous clear; older bits do not
    assign err_code_next = (i_clear_err ? 4'b0000 : err_code_reg) | {starve_hit, err_found};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase_reg    <= PH_SYNC;
            dwell_reg    <= '0;
            cycle_reg    <= '0;
            car_last_reg <= 1'b0;
            err_code_reg <= 4'b0000;
            err_reg      <= 1'b0;
        end else begin
            phase_reg    <= phase_next;
            dwell_reg    <= dwell_next;
            cycle_reg    <= cycle_next;
            car_last_reg <= car_last_next;
            err_code_reg <= err_code_next;
            err_reg      <= |err_code_next;
        end
    end

    assign o_phase     = phase_reg;
    assign o_dwell     = dwell_reg;
    assign o_cycle_cnt = cycle_reg;
    assign o_err_code  = err_code_reg;
    assign o_err       = err_reg;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor; expected values hand-derived, including the one-sample input pipeline.
module tb_traffic_light_monitor;

    localparam logic [2:0] L_R   = 3'b100;
    localparam logic [2:0] L_Y   = 3'b010;
    localparam logic [2:0] L_G   = 3'b001;
    localparam logic [2:0] L_BAD = 3'b110;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       red = 1'b0, yellow = 1'b0, green = 1'b0, car = 1'b0, clear_err = 1'b0;
    logic [1:0] phase;
    logic [7:0] dwell, cycle_cnt;
    logic [3:0] err_code;
    logic       err;

    int checks = 0;
    int errors = 0;

    traffic_light_monitor #(.CNT_W(8), .MAX_DWELL(1), .CAR_TIMEOUT(8)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_red       (red),
        .i_yellow    (yellow),
        .i_green     (green),
        .i_car       (car),
        .i_clear_err (clear_err),
        .o_phase     (phase),
        .o_dwell     (dwell),
        .o_cycle_cnt (cycle_cnt),
        .o_err_code  (err_code),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic drive(input logic [2:0] rgy, input logic c);
        {red, yellow, green} = rgy;
        car = c;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // 1: reset state, then red held with car low
        drive(L_R, 1'b0);
        reset = 1'b1;
        tick(2);
        check("rst_phase", phase, 0);
        check("rst_dwell", dwell, 0);
        check("rst_cycle", cycle_cnt, 0);
        check("rst_err_code", err_code, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        tick(11);
        check("t1_phase", phase, 1);
        check("t1_dwell", dwell, 10);
        check("t1_err_code", err_code, 0);

        // 2: one full legal cycle
        drive(L_R, 1'b1); tick(1);
        drive(L_Y, 1'b0); tick(1);
        drive(L_G, 1'b0); tick(1);
        drive(L_R, 1'b0); tick(1);
        tick(1);
        check("t2_cycle", cycle_cnt, 1);
        check("t2_phase", phase, 1);
        check("t2_dwell", dwell, 1);
        check("t2_err_code", err_code, 0);
        check("t2_err", err, 0);

        // 3: red straight to green
        drive(L_G, 1'b0); tick(2);
        check("t3_err_code", err_code, 4'b0010);
        check("t3_err", err, 1);
        check("t3_phase", phase, 3);
        check("t3_dwell", dwell, 1);
        // clear lands with a second green sample: dwell error survives the clear
        drive(L_R, 1'b0); clear_err = 1'b1; tick(1);
        check("t3_clear_vs_new", err_code, 4'b0100);
        tick(1);
        clear_err = 1'b0;
        check("t3_cleared", err_code, 0);
        check("t3_cycle", cycle_cnt, 2);

        // 4: multi-hot code holds phase, dwell keeps counting
        drive(L_BAD, 1'b0); tick(1);
        drive(L_R, 1'b0); tick(1);
        check("t4_err_code", err_code, 4'b0001);
        check("t4_phase", phase, 1);
        check("t4_dwell", dwell, 3);
        clear_err = 1'b1; tick(1); clear_err = 1'b0;
        check("t4_clear", err_code, 0);
        check("t4_err", err, 0);

        // 5: yellow overstays MAX_DWELL
        drive(L_R, 1'b1); tick(1);
        drive(L_Y, 1'b0); tick(2);
        check("t5_first_yellow", err_code, 0);
        check("t5_phase", phase, 2);
        tick(1);
        check("t5_second_yellow", err_code, 4'b0100);
        check("t5_dwell", dwell, 2);
        drive(L_G, 1'b0); tick(1);
        drive(L_R, 1'b0); tick(1);
        clear_err = 1'b1; tick(1); clear_err = 1'b0;
        check("t5_clear", err_code, 0);
        check("t5_cycle", cycle_cnt, 3);

        // 6: car starved in red
        drive(L_R, 1'b1); tick(1);
        tick(8);
        check("t6_eight_samples", err_code, 0);
        tick(1);
`ifdef TRAFFIC_MON_STARVE_CHK_EN
        check("t6_nine_samples", err_code, 4'b1000);
        check("t6_err", err, 1);
`else
        check("t6_nine_samples", err_code, 0);
        check("t6_err", err, 0);
`endif
        drive(L_R, 1'b0); tick(1);
        clear_err = 1'b1; tick(1); clear_err = 1'b0;
        check("t6_clear", err_code, 0);

        // 7: reset mid-green
        drive(L_R, 1'b1); tick(1);
        drive(L_Y, 1'b0); tick(1);
        drive(L_G, 1'b0); tick(2);
        check("t7_green", phase, 3);
        reset = 1'b1; tick(1); reset = 1'b0;
        check("t7_rst_phase", phase, 0);
        check("t7_rst_dwell", dwell, 0);
        check("t7_rst_cycle", cycle_cnt, 0);
        check("t7_rst_err_code", err_code, 0);
        check("t7_rst_err", err, 0);
        tick(1);
        check("t7_latency_phase", phase, 0);
        tick(1);
        check("t7_resync_phase", phase, 3);
        check("t7_resync_dwell", dwell, 1);
        check("t7_resync_err", err_code, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
